// File: rtl/riscv_multicycle_controller_if.sv
// Bundle of instruction fields, ALU flag and datapath controls between the
// multicycle controller and the RV32I datapath.
interface riscv_multicycle_controller_if;
    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zero;

    logic       o_pcWrite;
    logic       o_adrSrc;
    logic       o_memWrite;
    logic       o_irWrite;
    logic [1:0] o_resultSrc;
    logic [1:0] o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [1:0] o_immSrc;
    logic       o_regWrite;
    logic [3:0] o_aluControl;
    logic       o_retire;
    logic       o_illegal;

    // Controller side: consumes instruction fields, drives datapath controls.
    modport master (
        input  i_opcode, i_funct3, i_funct7b5, i_zero,
        output o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
               o_aluSrcA, o_aluSrcB, o_immSrc, o_regWrite, o_aluControl,
               o_retire, o_illegal
    );

    // Datapath side: supplies instruction fields, consumes controls.
    modport slave (
        output i_opcode, i_funct3, i_funct7b5, i_zero,
        input  o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
               o_aluSrcA, o_aluSrcB, o_immSrc, o_regWrite, o_aluControl,
               o_retire, o_illegal
    );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32I control unit (LW, SW, R-type ALU, I-type ALU, BEQ).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instr at PC into IR, PC <= PC + 4
// DECODE   | read regfile, ALUOut <= OldPC + imm (branch target), classify
// MEMADR   | ALUOut <= RD1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= loaded data, retire
// MEMWRITE | write RD2 to data memory at ALUOut, retire
// EXECUTER | ALUOut <= RD1 op RD2
// EXECUTEI | ALUOut <= RD1 op imm
// ALUWB    | rd <= ALUOut, retire
// BEQ      | compare RD1 - RD2, PC <= ALUOut when equal, retire
//
// Outputs are a combinational decode of the state register plus the held
// instruction fields and the current-cycle zero flag. The instruction
// fields are not latched here; the IR keeps them stable until retire.
module riscv_multicycle_controller #(
    parameter bit CHECK_FUNCT = 1'b1
) (
    input logic i_clk,
    input logic i_arst,
    riscv_multicycle_controller_if.master bus
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ
    } state_t;

    state_t state;

    logic op_ok;
    logic funct_ok;
    logic legal;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [3:0] alu_control;
    logic       retire;
    logic       illegal;

    // Instruction legality: opcode must be supported; funct fields are only
    // enforced when CHECK_FUNCT is set.
    always_comb begin
        op_ok    = 1'b0;
        funct_ok = 1'b0;
        case (bus.i_opcode)
            OP_LOAD, OP_STORE: begin
                op_ok    = 1'b1;
                funct_ok = (bus.i_funct3 == 3'b010);
            end
            OP_RTYPE: begin
                op_ok = 1'b1;
                case ({bus.i_funct7b5, bus.i_funct3})
                    4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100: funct_ok = 1'b1;
                    default:                                     funct_ok = 1'b0;
                endcase
            end
            OP_ITYPE: begin
                op_ok = 1'b1;
                case (bus.i_funct3)
                    3'b000, 3'b111, 3'b110, 3'b100: funct_ok = 1'b1;
                    default:                        funct_ok = 1'b0;
                endcase
            end
            OP_BTYPE: begin
                op_ok    = 1'b1;
                funct_ok = (bus.i_funct3 == 3'b000);
            end
            default: begin
                op_ok    = 1'b0;
                funct_ok = 1'b0;
            end
        endcase
        legal = op_ok && (funct_ok || !CHECK_FUNCT);
    end

    // State register and next-state sequencing; reset aborts to FETCH.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (!legal) begin
                        state <= S_FETCH;
                    end else begin
                        case (bus.i_opcode)
                            OP_LOAD, OP_STORE: state <= S_MEMADR;
                            OP_RTYPE:          state <= S_EXECUTER;
                            OP_ITYPE:          state <= S_EXECUTEI;
                            OP_BTYPE:          state <= S_BEQ;
                            default:           state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:   state <= (bus.i_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Immediate format follows the opcode alone, independent of state.
    always_comb begin
        case (bus.i_opcode)
            OP_STORE: imm_src = 2'b01;
            OP_BTYPE: imm_src = 2'b10;
            default:  imm_src = 2'b00;
        endcase
    end

    // Per-state datapath control decode; anything not set stays 0 / ADD.
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        reg_write   = 1'b0;
        alu_control = ALU_ADD;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal   = !legal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = {bus.i_funct7b5, bus.i_funct3};
            end
            S_EXECUTEI: begin
                // instr[30] is part of the immediate here, not an op modifier
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = {1'b0, bus.i_funct3};
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = bus.i_zero;
                retire      = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // Enables and pulses are blocked combinationally while reset is held so
    // nothing can commit between reset assertion and the clock edge.
    assign bus.o_pcWrite    = pc_write  & ~i_arst;
    assign bus.o_irWrite    = ir_write  & ~i_arst;
    assign bus.o_memWrite   = mem_write & ~i_arst;
    assign bus.o_regWrite   = reg_write & ~i_arst;
    assign bus.o_retire     = retire    & ~i_arst;
    assign bus.o_illegal    = illegal   & ~i_arst;
    assign bus.o_adrSrc     = adr_src;
    assign bus.o_resultSrc  = result_src;
    assign bus.o_aluSrcA    = alu_src_a;
    assign bus.o_aluSrcB    = alu_src_b;
    assign bus.o_immSrc     = imm_src;
    assign bus.o_aluControl = alu_control;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Self-checking bench for riscv_multicycle_controller: a vector table of
// instructions, each expanded into a per-cycle expected output trace that is
// queued and compared against the DUT every cycle.
module tb_riscv_multicycle_controller;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic       reg_write;
        logic [3:0] alu_control;
        logic       retire;
        logic       illegal;
    } out_t;

    typedef enum int {K_LW, K_SW, K_ALU_R, K_ALU_I, K_BEQ, K_ILL} kind_t;

    typedef struct {
        string      name;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic       f7b5;
        logic       zero;
        kind_t      kind;
        logic [3:0] ctl;
        logic [1:0] imm;
    } vec_t;

    logic clk = 1'b0;
    logic arst;

    riscv_multicycle_controller_if bus0 ();
    riscv_multicycle_controller_if bus1 ();

    assign bus1.i_opcode   = bus0.i_opcode;
    assign bus1.i_funct3   = bus0.i_funct3;
    assign bus1.i_funct7b5 = bus0.i_funct7b5;
    assign bus1.i_zero     = bus0.i_zero;

    riscv_multicycle_controller #(.CHECK_FUNCT(1'b1)) dut0 (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (bus0)
    );

    riscv_multicycle_controller #(.CHECK_FUNCT(1'b0)) dut1 (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    out_t q[$];
    vec_t vecs[16];

    function automatic out_t sample(int sel);
        out_t o;
        if (sel == 0) begin
            o.pc_write    = bus0.o_pcWrite;
            o.adr_src     = bus0.o_adrSrc;
            o.mem_write   = bus0.o_memWrite;
            o.ir_write    = bus0.o_irWrite;
            o.result_src  = bus0.o_resultSrc;
            o.alu_src_a   = bus0.o_aluSrcA;
            o.alu_src_b   = bus0.o_aluSrcB;
            o.imm_src     = bus0.o_immSrc;
            o.reg_write   = bus0.o_regWrite;
            o.alu_control = bus0.o_aluControl;
            o.retire      = bus0.o_retire;
            o.illegal     = bus0.o_illegal;
        end else begin
            o.pc_write    = bus1.o_pcWrite;
            o.adr_src     = bus1.o_adrSrc;
            o.mem_write   = bus1.o_memWrite;
            o.ir_write    = bus1.o_irWrite;
            o.result_src  = bus1.o_resultSrc;
            o.alu_src_a   = bus1.o_aluSrcA;
            o.alu_src_b   = bus1.o_aluSrcB;
            o.imm_src     = bus1.o_immSrc;
            o.reg_write   = bus1.o_regWrite;
            o.alu_control = bus1.o_aluControl;
            o.retire      = bus1.o_retire;
            o.illegal     = bus1.o_illegal;
        end
        return o;
    endfunction

    function automatic out_t fetch_exp(logic [1:0] imm);
        out_t o = '0;
        o.pc_write   = 1'b1;
        o.ir_write   = 1'b1;
        o.alu_src_b  = 2'b10;
        o.result_src = 2'b10;
        o.imm_src    = imm;
        return o;
    endfunction

    function automatic out_t reset_exp(logic [1:0] imm);
        out_t o = fetch_exp(imm);
        o.pc_write = 1'b0;
        o.ir_write = 1'b0;
        return o;
    endfunction

    function automatic int n_cycles(kind_t k);
        case (k)
            K_LW:             return 5;
            K_SW:             return 4;
            K_ALU_R, K_ALU_I: return 4;
            K_BEQ:            return 3;
            default:          return 2;
        endcase
    endfunction

    function automatic out_t exp_step(vec_t v, int step);
        out_t o = '0;
        o.imm_src = v.imm;
        if (step == 0) return fetch_exp(v.imm);
        if (step == 1) begin
            o.alu_src_a = 2'b01;
            o.alu_src_b = 2'b01;
            o.illegal   = (v.kind == K_ILL);
            return o;
        end
        case (v.kind)
            K_LW, K_SW: begin
                if (step == 2) begin
                    o.alu_src_a = 2'b10;
                    o.alu_src_b = 2'b01;
                end else if (step == 3) begin
                    o.adr_src = 1'b1;
                    if (v.kind == K_SW) begin
                        o.mem_write = 1'b1;
                        o.retire    = 1'b1;
                    end
                end else begin
                    o.result_src = 2'b01;
                    o.reg_write  = 1'b1;
                    o.retire     = 1'b1;
                end
            end
            K_ALU_R, K_ALU_I: begin
                if (step == 2) begin
                    o.alu_src_a   = 2'b10;
                    o.alu_src_b   = (v.kind == K_ALU_I) ? 2'b01 : 2'b00;
                    o.alu_control = v.ctl;
                end else begin
                    o.reg_write = 1'b1;
                    o.retire    = 1'b1;
                end
            end
            K_BEQ: begin
                o.alu_src_a   = 2'b10;
                o.alu_control = 4'b1000;
                o.pc_write    = v.zero;
                o.retire      = 1'b1;
            end
            default: o.illegal = 1'b0;
        endcase
        return o;
    endfunction

    task automatic check(string name, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus0.i_opcode   = v.opcode;
        bus0.i_funct3   = v.f3;
        bus0.i_funct7b5 = v.f7b5;
        bus0.i_zero     = v.zero;
    endtask

    // Entered just after a rising edge with the DUT in FETCH; leaves just
    // after the rising edge that should bring it back to FETCH.
    task automatic run_instr(int sel, vec_t v);
        int n;
        out_t e;
        drive(v);
        n = n_cycles(v.kind);
        for (int s = 0; s < n; s++) q.push_back(exp_step(v, s));
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            e = q.pop_front();
            check($sformatf("%s_c%0d", v.name, s), sample(sel), e);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t lw_v;
        vec_t sw_v;
        vec_t nc_v;
        out_t e;

        vecs[0]  = '{"lw",        7'b0000011, 3'b010, 1'b0, 1'b0, K_LW,    4'b0000, 2'b00};
        vecs[1]  = '{"sw",        7'b0100011, 3'b010, 1'b0, 1'b1, K_SW,    4'b0000, 2'b01};
        vecs[2]  = '{"sub",       7'b0110011, 3'b000, 1'b1, 1'b0, K_ALU_R, 4'b1000, 2'b00};
        vecs[3]  = '{"and",       7'b0110011, 3'b111, 1'b0, 1'b1, K_ALU_R, 4'b0111, 2'b00};
        vecs[4]  = '{"add",       7'b0110011, 3'b000, 1'b0, 1'b0, K_ALU_R, 4'b0000, 2'b00};
        vecs[5]  = '{"or",        7'b0110011, 3'b110, 1'b0, 1'b0, K_ALU_R, 4'b0110, 2'b00};
        vecs[6]  = '{"xori_b30",  7'b0010011, 3'b100, 1'b1, 1'b0, K_ALU_I, 4'b0100, 2'b00};
        vecs[7]  = '{"addi",      7'b0010011, 3'b000, 1'b0, 1'b1, K_ALU_I, 4'b0000, 2'b00};
        vecs[8]  = '{"beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, K_BEQ,   4'b1000, 2'b10};
        vecs[9]  = '{"beq_not",   7'b1100011, 3'b000, 1'b0, 1'b0, K_BEQ,   4'b1000, 2'b10};
        vecs[10] = '{"ill_jal",   7'b1101111, 3'b000, 1'b0, 1'b1, K_ILL,   4'b0000, 2'b00};
        vecs[11] = '{"ill_r001",  7'b0110011, 3'b001, 1'b0, 1'b0, K_ILL,   4'b0000, 2'b00};
        vecs[12] = '{"ill_lw000", 7'b0000011, 3'b000, 1'b0, 1'b0, K_ILL,   4'b0000, 2'b00};
        vecs[13] = '{"ill_bne",   7'b1100011, 3'b001, 1'b0, 1'b1, K_ILL,   4'b0000, 2'b10};
        vecs[14] = '{"ill_slli",  7'b0010011, 3'b001, 1'b0, 1'b0, K_ILL,   4'b0000, 2'b00};
        vecs[15] = '{"ill_r1111", 7'b0110011, 3'b111, 1'b1, 1'b0, K_ILL,   4'b0000, 2'b00};

        lw_v = vecs[0];
        sw_v = vecs[1];
        nc_v = '{"nocheck_r001", 7'b0110011, 3'b001, 1'b0, 1'b0, K_ALU_R, 4'b0001, 2'b00};

        arst = 1'b1;
        drive('{"idle", 7'b0000000, 3'b000, 1'b0, 1'b0, K_ILL, 4'b0000, 2'b00});
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", sample(0), reset_exp(2'b00));
        @(posedge clk);
        #2 arst = 1'b0;
        #1 check("reset_release", sample(0), fetch_exp(2'b00));

        foreach (vecs[i]) run_instr(0, vecs[i]);

        // Reset asserted in MEMREAD: abort to FETCH with all writes blocked.
        drive(lw_v);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            e = exp_step(lw_v, s);
            check($sformatf("lw_abort_c%0d", s), sample(0), e);
            if (s < 3) begin
                @(posedge clk);
                #1;
            end
        end
        #1 arst = 1'b1;
        #1 check("rst_mid_memread", sample(0), reset_exp(2'b00));
        @(posedge clk);
        #1 check("rst_held_edge", sample(0), reset_exp(2'b00));
        #1 arst = 1'b0;
        #1 check("rst_release_fetch", sample(0), fetch_exp(2'b00));
        run_instr(0, sw_v);
        @(negedge clk);
        check("after_sw_fetch", sample(0), fetch_exp(2'b01));

        // Funct checking disabled: unsupported R-type funct3 runs as an ALU op.
        @(posedge clk);
        arst = 1'b1;
        @(posedge clk);
        #2 arst = 1'b0;
        #1;
        run_instr(1, nc_v);
        @(negedge clk);
        check("nocheck_back_to_fetch", sample(1), fetch_exp(2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
Control unit for the multicycle RV32I core. It decodes the pa_riscv opcode and funct fields from the instruction register and sequences each instruction through a Moore FSM. It drives the datapath mux selects, write enables, and the ALU operation code. The ALU operation code uses ty_ALU_OP encoding and feeds the ALU directly downstream. Supported instructions are LW, SW, R-type ALU, I-type ALU and BEQ.

Parameters:
CHECK_FUNCT, 1, when 1 unsupported funct3/funct7 combinations are illegal; when 0 only the opcode is checked.

Ports:
i_clk  in  1  clock, rising edge
i_arst  in  1  asynchronous active-high reset
i_opcode  in  7  instr[6:0], ty_INSTRUCTION_TYPE
i_funct3  in  3  instr[14:12]
i_funct7b5  in  1  instr[30]
i_zero  in  1  ALU zero flag (combinational, current cycle)
o_pcWrite  out  1  PC register enable
o_adrSrc  out  1  memory address select: 0=PC, 1=Result
o_memWrite  out  1  data memory write enable
o_irWrite  out  1  instruction register / OldPC enable
o_resultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
o_aluSrcA  out  2  00=PC, 01=OldPC, 10=RD1
o_aluSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
o_immSrc  out  2  00=I, 01=S, 10=B; combinational from i_opcode, 00 for others
o_regWrite  out  1  register file write enable
o_aluControl  out  4  ty_ALU_OP
o_retire  out  1  1-cycle pulse in final state of each instruction
o_illegal  out  1  1-cycle pulse in DECODE on an unsupported instruction

Behaviour:
- State register, async reset to FETCH.
- While i_arst=1: o_pcWrite, o_irWrite, o_memWrite, o_regWrite, o_retire and o_illegal are forced 0. Other outputs show the FETCH decode.
- Reset mid-instruction aborts to FETCH; no partial write occurs after reset is asserted.
- Outputs are a combinational decode of the state plus funct/zero. Unlisted outputs in a state are 0, and o_aluControl defaults to ADD.
- FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, resultSrc=10, ADD, pcWrite=1. Next state is DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, ADD (branch target into ALUOut). Next state by opcode:
  - LW or SW -> MEMADR
  - R_TYPE_ALU -> EXECUTER
  - I_TYPE_ALU -> EXECUTEI
  - B_TYPE -> BEQ
  - unsupported -> FETCH, with o_illegal=1 and no writes
- Legality when CHECK_FUNCT=1:
  - LW/SW: funct3=010.
  - R-type: {funct7b5,funct3} is one of 0000, 1000, 0111, 0110, 0100.
  - I-type: funct3 is one of 000, 111, 110, 100.
  - B_TYPE: funct3=000.
- MEMADR: aluSrcA=10, aluSrcB=01, ADD. Next state: LW -> MEMREAD, SW -> MEMWRITE.
- MEMREAD: resultSrc=00, adrSrc=1. Next state is MEMWB.
- MEMWB: resultSrc=01, regWrite=1, retire=1. Next state is FETCH.
- MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1, retire=1. Next state is FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluControl={funct7b5,funct3}. Next state is ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluControl={1'b0,funct3}; funct7b5 is ignored. Next state is ALUWB.
- ALUWB: resultSrc=00, regWrite=1, retire=1. Next state is FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, SUB, resultSrc=00, pcWrite=i_zero, retire=1. Next state is FETCH.
- Cycle counts: LW 5, SW 4, R/I 4, BEQ 3, illegal 2.
- Opcode/funct inputs must be stable from the cycle after FETCH until retire (IR held). The controller does not latch them.

Test Plan:
- Reset: assert i_arst mid-MEMREAD, release -> state FETCH; pcWrite=irWrite=memWrite=regWrite=0 while reset is held; first cycle after release shows pcWrite=1, irWrite=1, aluSrcB=10.
- LW (opcode 0000011, funct3 010) -> 5 cycles. MEMADR shows aluSrcA=10, aluSrcB=01, immSrc=00. MEMREAD shows adrSrc=1. MEMWB shows resultSrc=01, regWrite=1, retire=1.
- SW (0100011, funct3 010) -> 4 cycles, immSrc=01. MEMWRITE shows memWrite=1, adrSrc=1, regWrite=0.
- R-type SUB (funct7b5=1, funct3 000) -> EXECUTER shows aluControl=1000. AND -> 0111. ALUWB shows regWrite=1.
- I-type XORI with instr[30]=1 -> EXECUTEI shows aluControl=0100.
- BEQ with i_zero=1 -> BEQ state shows pcWrite=1, aluControl=1000, resultSrc=00; with i_zero=0 -> pcWrite=0. Both cases take 3 cycles.
- Illegal: opcode 1101111 -> DECODE shows illegal=1, then FETCH, with no write enables. R-type funct3=001 also gives illegal with CHECK_FUNCT=1, and a 4-cycle retire with CHECK_FUNCT=0.
